// File: rtl/phase_pkg.sv
// Shared types and fixed-point constants for the phase extraction chain.
// Angles are degrees in 32-bit two's complement with 8 fractional bits.
package phase_pkg;

  localparam int FP_FRAC = 8;
  localparam logic signed [32:0] DEG180_FP = 33'sd46080;
  localparam logic signed [32:0] DEG360_FP = 33'sd92160;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DRAIN
  } state_t;

  localparam int ERR_TMO = 0;
  localparam int ERR_FFT = 1;
  localparam int ERR_OVR = 2;

endpackage

// File: rtl/phase_wrap.sv
// Combinational phase difference a-b wrapped into (-180.0, 180.0].
// Difference is formed at 33 bits so no input pair can overflow.
module phase_wrap
  import phase_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] d
);

  logic signed [32:0] diff;
  logic signed [32:0] wrapped;

  // subtract, then fold by one turn when outside the half-open range
  always_comb begin
    diff    = $signed({a[31], a}) - $signed({b[31], b});
    wrapped = diff;
    if (diff > DEG180_FP)
      wrapped = diff - DEG360_FP;
    else if (diff <= -DEG180_FP)
      wrapped = diff + DEG360_FP;
  end

  assign d = 32'(wrapped);

endmodule

// File: rtl/phase_run_ctrl.sv
// Measurement sequencer: resets the FFT/peak chain, collects RUNS
// peak results and hands each out as a wrapped phase difference.
module phase_run_ctrl
  import phase_pkg::*;
#(
  parameter int RUNS       = 3,
  parameter int RST_CYCLES = 8,
  parameter int TIMEOUT    = 65536,
  parameter int CNT_W      = 17,
  parameter int RUN_W      = (RUNS > 1) ? $clog2(RUNS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  output logic             buff_reset,
  output logic             fft_aclr,
  output logic             peak_reset,
  input  logic             fft_sop,
  input  logic             fft_valid,
  input  logic             fft_error,
  input  logic             peak_valid,
  input  logic             peak_eop,
  input  logic [31:0]      peak_freq,
  input  logic [31:0]      peak_mag,
  input  logic [31:0]      peak_phaseA,
  input  logic [31:0]      peak_phaseB,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RUN_W-1:0] res_run,
  output logic [31:0]      res_freq,
  output logic [31:0]      res_mag,
  output logic [31:0]      res_dphase,
  output logic             busy,
  output logic             done,
  output logic [2:0]       err
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  state_t           state, state_nx;
  logic [RC_W-1:0]  rst_cnt;
  logic [RUN_W-1:0] cap_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       frames_in;
  logic [31:0]      dphase_w;

  logic hs, cap, last, tmo_hit;
  logic load, done_nx, rv_nx;
  logic set_tmo, set_fft, set_ovr;

  phase_wrap u_wrap (
    .a (peak_phaseA),
    .b (peak_phaseB),
    .d (dphase_w)
  );

  assign hs      = res_valid & res_ready;
  assign cap     = (state == RUN) & peak_valid & peak_eop;
  assign last    = cap_cnt == RUN_W'(RUNS - 1);
  assign tmo_hit = tmo_cnt == CNT_W'(TIMEOUT - 1);

  assign buff_reset = (state == IDLE) | (state == RESET);
  assign fft_aclr   = buff_reset;
  assign peak_reset = buff_reset;
  assign busy       = state != IDLE;

  // next state, error events and result-slot control
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    set_tmo  = 1'b0;
    set_fft  = 1'b0;
    set_ovr  = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nx = RESET;
      RESET: if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_nx = RUN;
      RUN: begin
        if (fft_error) begin
          set_fft  = 1'b1;
          state_nx = IDLE;
        end else if (cap) begin
          load    = !res_valid || hs;
          set_ovr = res_valid && !hs;
          if (last) state_nx = DRAIN;
        end else if (tmo_hit) begin
          set_tmo  = 1'b1;
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (!res_valid || hs) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
      set_tmo  = 1'b0;
      set_fft  = 1'b0;
      set_ovr  = 1'b0;
      load     = 1'b0;
    end
    rv_nx = res_valid;
    if (abort)     rv_nx = 1'b0;
    else if (load) rv_nx = 1'b1;
    else if (hs)   rv_nx = 1'b0;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
    end
  end

  // run counters and sticky errors
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rst_cnt   <= '0;
      cap_cnt   <= '0;
      tmo_cnt   <= '0;
      frames_in <= '0;
      err       <= '0;
    end else begin
      rst_cnt <= (state == RESET) ? rst_cnt + 1'b1 : '0;
      tmo_cnt <= (state == RUN && !cap) ? tmo_cnt + 1'b1 : '0;
      if (state == IDLE && start && !abort) begin
        cap_cnt   <= '0;
        frames_in <= '0;
        err       <= '0;
      end else begin
        if (cap) cap_cnt <= cap_cnt + 1'b1;
        if (state == RUN && fft_sop && fft_valid && !(&frames_in))
          frames_in <= frames_in + 1'b1;
        err <= err | {set_ovr, set_fft, set_tmo};
      end
    end
  end

  // result slot with valid/ready handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_valid  <= 1'b0;
      res_run    <= '0;
      res_freq   <= '0;
      res_mag    <= '0;
      res_dphase <= '0;
    end else begin
      res_valid <= rv_nx;
      if (load) begin
        res_run    <= cap_cnt;
        res_freq   <= peak_freq;
        res_mag    <= peak_mag;
        res_dphase <= dphase_w;
      end
    end
  end

endmodule

// File: doc/phase_run_ctrl.md
Name: phase_run_ctrl

Overview:
- Single-clock sequencer for the phase extraction chain: input buffer -> fft_int -> peak_detect.
- On `start` it resets the chain, then counts RUNS FFT frames in and RUNS peak results out.
- Each captured peak is converted to a wrapped phase difference and presented on a valid/ready result port.
- Flags timeout, FFT error and result overrun; replaces the free-running initial-block resets in the phase extraction top level.

Parameters:
RUNS, 3, number of frames per measurement.
RST_CYCLES, 8, cycles the datapath resets are held; covers ≥2 clk20 edges.
TIMEOUT, 65536, max clk cycles allowed between start-of-run and peak result.
CNT_W, 17, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
clk  in  1  main clock
reset_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a measurement, ignored unless busy=0
abort  in  1  one-cycle pulse; returns to IDLE from any state
buff_reset  out  1  reset to input_buffer (active-high)
fft_aclr  out  1  reset to fft_int (active-high)
peak_reset  out  1  reset to peak_detect (active-high)
fft_sop  in  1  observed time_fft_sop into fft_int
fft_valid  in  1  observed time_fft_valid into fft_int
fft_error  in  1  error from fft_int
peak_valid  in  1  peak_detect source_valid
peak_eop  in  1  peak_detect source_eop
peak_freq  in  32  kHz, FP (32-bit two's complement, 8 fractional bits)
peak_mag  in  32  magnitude, FP
peak_phaseA  in  32  deg, FP
peak_phaseB  in  32  deg, FP
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_run  out  2  run index 0..RUNS-1 (width $clog2(RUNS), min 1)
res_freq  out  32  captured peak_freq
res_mag  out  32  captured peak_mag
res_dphase  out  32  wrapped phaseA-phaseB, FP deg
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last result accepted
err  out  3  sticky {overrun, fft_err, timeout}; cleared on start

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; buff_reset=fft_aclr=peak_reset=1; res_valid=0; all res_* =0; busy=0; done=0; err=0; counters=0.
- Resets are also held asserted throughout IDLE, so the datapath is quiescent.
- States and transitions:
  - IDLE: start -> RESET (err cleared, run counters cleared).
  - RESET: resets asserted for RST_CYCLES cycles, then deasserted; -> RUN.
  - RUN: frames_in increments on fft_sop&fft_valid. Captures occur on peak_valid&peak_eop, up to RUNS captures. After the RUNS-th capture -> DRAIN.
  - DRAIN: waits for the last result to be accepted (res_valid=0 after handshake); -> IDLE with done=1 for one cycle.
- Any state, abort=1: -> IDLE next cycle, res_valid cleared, no done pulse.
- Any state, fft_error=1 in RUN: err[1] set, -> IDLE, no done pulse.
- Timeout:
  - Counter clears on entering RUN and on each capture; increments otherwise in RUN.
  - Reaching TIMEOUT sets err[0] and forces IDLE.
- Capture:
  - On the capture cycle the four peak fields register; res_valid=1 on the next cycle (latency 1).
  - res_run = capture index.
- Phase arithmetic:
  - d = phaseA - phaseB is computed at 33 bits.
  - If d > 46080 (180.0) subtract 92160; if d <= -46080 add 92160.
  - Result range is (-180.0, 180.0]; truncate to 32 bits.
- Handshake:
  - Result transfers on res_valid&res_ready; res_valid drops the next cycle unless a new capture occurs that same cycle.
  - res_* stays stable while res_valid=1 and res_ready=0.
- Overrun: capture while res_valid=1 and no handshake that cycle:
  - err[2] set; the new result is dropped but still counts toward RUNS.
- Simultaneous capture and handshake: the new result replaces the old one, no overrun.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- frames_in vs captures: if frames_in exceeds captures by more than 2, timeout still governs; no separate error.

Decomposition:
- Package phase_pkg holds:
  - FP constants: FP_FRAC=8, DEG180_FP=46080, DEG360_FP=92160.
  - state enum {IDLE, RESET, RUN, DRAIN}.
  - error bit indices.
- One sub-module, phase_wrap: registered-input-free combinational d = A-B with ±360 wrap; reused by later stages.

Test Plan:
- Nominal: start, 3 peaks with phaseA=10.0 (2560), phaseB=4.0 (1024), res_ready=1 -> 3 results, res_dphase=1536, res_run=0,1,2, one done pulse, err=0.
- Wrap: phaseA=170.0 (43520), phaseB=-170.0 (-43520) -> res_dphase=-5120 (-20.0); A=-180.0, B=0 -> +46080.
- Backpressure: res_ready=0 for 20 cycles, second peak arrives -> err=3'b100, first result held stable, done after 3 captures and final accept.
- Timeout: TIMEOUT=100, no peak_valid -> err=3'b001 at cycle 100 after RUN entry, busy=0, resets reasserted, no done.
- Abort/reset mid-run: abort after 1 capture -> IDLE next cycle, res_valid=0. reset_n low mid-RUN -> all outputs at reset values next posedge.
- Reset timing: after start, buff_reset/fft_aclr/peak_reset high exactly RST_CYCLES cycles, then low. fft_error pulse in RUN -> err=3'b010.
